// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
// Holds the clear-sweep state encoding and the address-width helper.
package reg_file_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   // Smallest r with 2**r >= value; usable in constant expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Post-reset clear sweep controller: zeroes every register, then hands the
// array write port over to the external writer and flags discarded writes.
module reg_file_clear_fsm
   import reg_file_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int ZERO_REG = 1,
   parameter int AW       = clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   output logic            ready,
   output logic            wr_dropped,
   output logic            arr_we,
   output logic [AW-1:0]   arr_addr,
   output logic [XLEN-1:0] arr_data
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t        state, state_next;
   logic [AW-1:0] clr_idx, clr_idx_next;
   logic          drop_next;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLEAR;
         clr_idx    <= '0;
         wr_dropped <= 1'b0;
      end else begin
         state      <= state_next;
         clr_idx    <= clr_idx_next;
         wr_dropped <= drop_next;
      end
   end

   // NOTE: every output gets a default before the case, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_next   = state;
      clr_idx_next = clr_idx;
      drop_next    = 1'b0;
      ready        = 1'b0;
      arr_we       = 1'b0;
      arr_addr     = waddr;
      arr_data     = wdata;
      case (state)
         CLEAR: begin
            arr_we    = 1'b1;
            arr_addr  = clr_idx;
            arr_data  = '0;
            drop_next = we;
            if (clr_idx == LAST_IDX) state_next = READY;
            else                     clr_idx_next = clr_idx + 1'b1;
         end
         READY: begin
            ready  = 1'b1;
            // A register-0 write is an architectural no-op, not a drop.
            arr_we = we && !((ZERO_REG != 0) && (waddr == '0));
         end
         default: state_next = CLEAR;
      endcase
   end

endmodule

// File: rtl/reg_file_multiport.sv
// Parametrised register file: NRD combinational read ports, one write port,
// optional hardwired-zero register 0 and optional write-to-read bypass.
module reg_file_multiport
   import reg_file_pkg::*;
#(
   parameter  int XLEN     = XLEN_DEF,
   parameter  int NREGS    = NREGS_DEF,
   parameter  int NRD      = 2,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic                ready,
   output logic                wr_dropped
);

   logic            arr_we;
   logic [AW-1:0]   arr_addr;
   logic [XLEN-1:0] arr_data;
   logic [XLEN-1:0] mem [NREGS];

   reg_file_clear_fsm #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_clear_fsm (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .ready      (ready),
      .wr_dropped (wr_dropped),
      .arr_we     (arr_we),
      .arr_addr   (arr_addr),
      .arr_data   (arr_data)
   );

   // NOTE: the array has no reset; the clear sweep zeroes it and reads are
   // forced to zero until the sweep finishes, so contents are never exposed.
   always_ff @(posedge clk) begin
      if (arr_we) mem[arr_addr] <= arr_data;
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] addr;
      logic          zero_hit;
      logic          bypass_hit;

      assign addr       = raddr[i*AW +: AW];
      assign zero_hit   = (ZERO_REG != 0) && (addr == '0);
      assign bypass_hit = (BYPASS != 0) && ready && we && (waddr == addr);

      // zero_hit wins over bypass, which covers the discarded register-0 write.
      assign rdata[i*XLEN +: XLEN] = (!ready || zero_hit) ? '0
                                   : bypass_hit            ? wdata
                                   : mem[addr];
   end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed bench for reg_file_multiport: default build, a no-zero/no-bypass
// build sharing its stimulus, and a small 3-port 16x8 build for reset restart.
module tb_reg_file_multiport;

   logic        clk = 1'b0;
   logic        rst, we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [9:0]  raddr;
   logic [63:0] rdata_a, rdata_b;
   logic        ready_a, ready_b, drop_a, drop_b;

   logic        rst_c, we_c;
   logic [2:0]  waddr_c;
   logic [15:0] wdata_c;
   logic [8:0]  raddr_c;
   logic [47:0] rdata_c;
   logic        ready_c, drop_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_file_multiport dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_a), .ready(ready_a), .wr_dropped(drop_a)
   );

   reg_file_multiport #(.ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_b), .ready(ready_b), .wr_dropped(drop_b)
   );

   reg_file_multiport #(.XLEN(16), .NREGS(8), .NRD(3)) dut_c (
      .clk(clk), .rst(rst_c), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
      .raddr(raddr_c), .rdata(rdata_c), .ready(ready_c), .wr_dropped(drop_c)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nz, drop_hi, drop_lo, drop_b_seen, nz_all;

      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = {5'd3, 5'd9};
      rst_c = 1'b1; we_c = 1'b0; waddr_c = '0; wdata_c = '0; raddr_c = '0;
      #1;
      check("rst_ready_a", 64'(ready_a), 64'd0);
      check("rst_drop_a", 64'(drop_a), 64'd0);
      check("rst_ready_c", 64'(ready_c), 64'd0);
      repeat (3) tick;
      rst = 1'b0;

      // Sweep: count edges until ready, drop a write on sweep cycle 10.
      n = 0; nz = 0; drop_hi = 0; drop_lo = 1; drop_b_seen = 0;
      while (!ready_a && n < 100) begin
         if (rdata_a != 0 || rdata_b != 0) nz++;
         we = (n == 10); waddr = 5'd3; wdata = 32'hAAAA_5555;
         tick; n++;
         if (n == 11) begin drop_hi = int'(drop_a); drop_b_seen = int'(drop_b); end
         if (n == 12) drop_lo = int'(drop_a);
      end
      we = 1'b0;
      check("sweep_len", 64'(n), 64'd32);
      check("sweep_rdata_zero", 64'(nz), 64'd0);
      check("sweep_drop_pulse", 64'(drop_hi), 64'd1);
      check("sweep_drop_b_pulse", 64'(drop_b_seen), 64'd1);
      check("sweep_drop_end", 64'(drop_lo), 64'd0);

      nz_all = 0;
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(a), 5'(a)};
         #1;
         if (rdata_a != 0 || rdata_b != 0) nz_all++;
      end
      check("post_sweep_all_zero", 64'(nz_all), 64'd0);
      raddr = {5'd3, 5'd3}; #1;
      check("dropped_addr3", rdata_a, 64'd0);

      // Basic write/read.
      we = 1'b1; waddr = 5'd5; wdata = 32'h0000_0005; tick;
      waddr = 5'd6; wdata = 32'h0000_0004; tick;
      we = 1'b0; raddr = {5'd6, 5'd5}; #1;
      check("basic_a", rdata_a, {32'h4, 32'h5});
      check("basic_b", rdata_b, {32'h4, 32'h5});

      // Zero register.
      we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF; raddr = {5'd0, 5'd0}; #1;
      check("zero_bypass_a", rdata_a[31:0], 64'd0);
      tick;
      we = 1'b0; #1;
      check("zero_read_a", rdata_a, 64'd0);
      check("zero_nodrop_a", 64'(drop_a), 64'd0);
      check("zero_read_b", rdata_b, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

      // Bypass, both ports on the same address.
      we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; raddr = {5'd7, 5'd7}; #1;
      check("bypass_a", rdata_a, {32'h1234_5678, 32'h1234_5678});
      check("nobypass_b", rdata_b, 64'd0);
      tick;
      we = 1'b0; #1;
      check("after_edge_b", rdata_b[31:0], 64'h1234_5678);

      // Small build: initial sweep, write, mid-operation reset.
      rst_c = 1'b0;
      n = 0;
      while (!ready_c && n < 50) begin tick; n++; end
      check("c_sweep_len", 64'(n), 64'd8);
      we_c = 1'b1; waddr_c = 3'd2; wdata_c = 16'h00FF; tick;
      we_c = 1'b0; raddr_c = {3'd2, 3'd2, 3'd2}; #1;
      check("c_write", 64'(rdata_c), 64'({3{16'h00FF}}));
      rst_c = 1'b1; we_c = 1'b1; waddr_c = 3'd4; wdata_c = 16'h1234; #1;
      check("c_ready_async_drop", 64'(ready_c), 64'd0);
      check("c_rdata_in_reset", 64'(rdata_c), 64'd0);
      tick; tick;
      rst_c = 1'b0; we_c = 1'b0;
      n = 0;
      while (!ready_c && n < 50) begin tick; n++; end
      check("c_resweep_len", 64'(n), 64'd8);
      #1;
      check("c_addr2_cleared", 64'(rdata_c), 64'd0);
      raddr_c = {3'd4, 3'd4, 3'd4}; #1;
      check("c_inflight_lost", 64'(rdata_c), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file_multiport.md
Name: reg_file_multiport

Overview:
Parametrised general-purpose register file for the single-cycle core. Generalises the fixed 32x32, 2-read/1-write file in four ways: configurable width, depth and read-port count; an optional hardwired-zero register 0; optional write-to-read bypass; and a hardware clear sweep after reset. The decode stage reads from it and the writeback stage writes to it. The core holds fetch while `ready` is low.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, register count; power of two, at least 2.
- NRD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- we, in, 1, write enable.
- waddr, in, AW, write address; AW = clog2(NREGS).
- wdata, in, XLEN, write data.
- raddr, in, NRD*AW, packed read addresses; port i occupies [i*AW +: AW].
- rdata, out, NRD*XLEN, packed read data; port i occupies [i*XLEN +: XLEN].
- ready, out, 1, high once the clear sweep has completed.
- wr_dropped, out, 1, registered one-cycle pulse for a write that was ignored.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- FSM states: CLEAR and READY.
- rst asserted:
  - state = CLEAR, clr_idx = 0, ready = 0, wr_dropped = 0.
  - The storage array is not reset asynchronously; the sweep clears it.
- CLEAR state:
  - Each posedge writes 0 to reg[clr_idx] and increments clr_idx.
  - At clr_idx == NREGS-1 the final zero is written and state becomes READY on that edge.
  - ready therefore rises exactly NREGS rising edges after rst deasserts.
  - All rdata ports output 0 throughout CLEAR.
  - A write with we=1 during CLEAR is discarded. wr_dropped = 1 on the following cycle.
- READY state:
  - Holds until the next rst. ready = 1.
  - Write on posedge when we=1.
  - If ZERO_REG=1 and waddr == 0, the write is discarded. No wr_dropped pulse for this case (architectural no-op).
- Reads:
  - Combinational; zero latency.
  - rdata_i = reg[raddr_i], except in the cases below.
  - If ZERO_REG=1 and raddr_i == 0, rdata_i = 0 regardless of array contents.
  - Bypass: if BYPASS=1, state is READY, we=1, waddr == raddr_i, and waddr is not a discarded zero-register write, then rdata_i = wdata in the same cycle.
  - If BYPASS=0, reads return the old value until the edge.
- Multiple read ports may use the same address; each resolves independently with identical rules.
- rst asserted mid-sweep or mid-operation:
  - Restarts the sweep from clr_idx = 0 and drops ready immediately (asynchronously).
  - Any in-flight write on that edge is lost.
- clr_idx is AW bits wide. The terminal compare is on NREGS-1, so there is no wrap-around.
- No X propagation: unwritten locations are never readable before ready = 1.

Decomposition:
- Shared package reg_file_pkg:
  - State enum {CLEAR, READY}.
  - clog2 helper function.
  - Localparam defaults XLEN_DEF = 32 and NREGS_DEF = 32.
- One natural sub-module, reg_file_clear_fsm:
  - Owns the state, clr_idx, ready and wr_dropped.
  - Outputs the effective write enable, address and data to the storage array (sweep mux versus external write).
- Top level holds:
  - The storage array.
  - The per-port read/zero/bypass logic, built as a generate loop over NRD.

Test Plan:
- Reset sweep: assert rst for 3 cycles, then release → ready = 0 for exactly 32 edges and 1 after the 32nd. All rdata = 0 during the sweep. After the sweep, every address reads 0x00000000.
- Basic write/read: we=1, waddr=5, wdata=0x00000005; next cycle we=1, waddr=6, wdata=0x00000004 → afterwards raddr0=5 gives 0x00000005 and raddr1=6 gives 0x00000004.
- Zero register: write 0xDEADBEEF to address 0 → rdata for address 0 stays 0x00000000 and wr_dropped stays 0. With ZERO_REG=0, the same sequence reads back 0xDEADBEEF.
- Bypass: in the same cycle, we=1, waddr=7, wdata=0x12345678 and raddr0=7 → rdata0 = 0x12345678 combinationally. With BYPASS=0, rdata0 shows the prior value (0) until the edge.
- Drop during sweep: we=1, waddr=3, wdata=0xAAAA5555 on sweep cycle 10 → wr_dropped pulses high for one cycle. After ready, address 3 reads 0x00000000.
- Mid-operation reset, with NRD=3, XLEN=16, NREGS=8: write 0x00FF to address 2, then assert rst → ready drops the same cycle. After release, ready rises 8 edges later and address 2 reads 0x0000 on all three ports.
